// File: rtl/complete_arbiter_pkg.sv
// Shared types and constants for the completion-stage arbiter.
// The branch FU sits at the top index so round-robin wrap naturally steps over it.
package complete_arbiter_pkg;

  localparam int NUM_FU         = 8;
  localparam int COMPLETE_WIDTH = 2;
  localparam int BRANCH_IDX     = 7;
  localparam int PTR_W          = $clog2(NUM_FU);
  localparam int CNT_W          = $clog2(COMPLETE_WIDTH + 1);

  typedef logic [NUM_FU-1:0] FU_STATE_PACKET;

  typedef struct packed {
    logic        valid;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
    logic        if_take_branch;
    logic [31:0] target_pc;
    logic        halt;
  } FU_COMPLETE_PACKET;

  // Pointer successor that never rests on the branch FU.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
    logic [PTR_W-1:0] nxt;
    nxt = (idx == PTR_W'(NUM_FU - 1)) ? PTR_W'(0) : idx + PTR_W'(1);
    if (nxt == PTR_W'(BRANCH_IDX)) begin
      nxt = (nxt == PTR_W'(NUM_FU - 1)) ? PTR_W'(0) : nxt + PTR_W'(1);
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  function automatic logic [PTR_W-1:0] oh_to_idx(input FU_STATE_PACKET oh);
    logic [PTR_W-1:0] idx;
    idx = PTR_W'(0);
    for (int i = 0; i < NUM_FU; i++) begin
      idx = oh[i] ? (idx | PTR_W'(i)) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-to-arbiter completion handshake; master is the FU side, slave the arbiter.
interface complete_arbiter_if;
  import complete_arbiter_pkg::*;

  FU_STATE_PACKET    want_to_complete;
  FU_COMPLETE_PACKET fu_packet_in [NUM_FU];
  FU_STATE_PACKET    complete_stall;
  FU_COMPLETE_PACKET complete_out [COMPLETE_WIDTH];

  modport master (
    output want_to_complete, fu_packet_in,
    input  complete_stall, complete_out
  );

  modport slave (
    input  want_to_complete, fu_packet_in,
    output complete_stall, complete_out
  );

endinterface

// File: rtl/complete_arbiter_rr_select.sv
// Combinational cyclic picker: up to `count` requesters scanned from `start`,
// returned as one one-hot vector per pick in scan order.
module rr_select #(
  parameter int N  = 8,
  parameter int W  = 2,
  parameter int PW = $clog2(N),
  parameter int CW = $clog2(W + 1)
) (
  input  logic [N-1:0]        req,
  input  logic [PW-1:0]       start,
  input  logic [CW-1:0]       count,
  output logic [W-1:0][N-1:0] pick_oh,
  output logic [W-1:0]        pick_vld
);

  int          taken;
  logic [PW-1:0] idx;

  // Walk the ring once, filling pick slots in order until count is reached.
  always_comb begin
    pick_oh  = '0;
    pick_vld = '0;
    taken    = 0;
    idx      = PW'(0);
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(start) + k) % N);
      if (req[idx] && (taken < int'(count)) && (taken < W)) begin
        for (int w = 0; w < W; w++) begin
          pick_oh[w][idx] = pick_oh[w][idx] | (w == taken);
          pick_vld[w]     = pick_vld[w] | (w == taken);
        end
        taken = taken + 1;
      end else begin
        taken = taken;
      end
    end
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: branch FU gets slot 0, the remaining slots go round-robin
// to the other FUs; granted packets are registered onto the completion bus.
module complete_arbiter
  import complete_arbiter_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  complete_arbiter_if.slave        bus
);

  FU_STATE_PACKET                           eff_req_s;
  FU_STATE_PACKET                           nb_req_s;
  FU_STATE_PACKET                           grant_s;
  logic                                     branch_go_s;
  logic [CNT_W-1:0]                         nb_count_s;
  logic [COMPLETE_WIDTH-1:0][NUM_FU-1:0]    pick_oh_s;
  logic [COMPLETE_WIDTH-1:0]                pick_vld_s;
  FU_COMPLETE_PACKET                        pick_pkt_s [COMPLETE_WIDTH];
  FU_COMPLETE_PACKET                        out_nxt_s  [COMPLETE_WIDTH];
  logic [PTR_W-1:0]                         rr_ptr_r;
  logic [PTR_W-1:0]                         rr_ptr_nxt_s;

  // Qualify requests; reset and squash suppress every grant so all requesters stall.
  always_comb begin
    eff_req_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      eff_req_s[i] = bus.want_to_complete[i] & bus.fu_packet_in[i].valid & ~reset & ~squash;
    end
    branch_go_s          = eff_req_s[BRANCH_IDX];
    nb_req_s             = eff_req_s;
    nb_req_s[BRANCH_IDX] = 1'b0;
    nb_count_s = branch_go_s ? CNT_W'(COMPLETE_WIDTH - 1) : CNT_W'(COMPLETE_WIDTH);
  end

  rr_select #(
    .N (NUM_FU),
    .W (COMPLETE_WIDTH)
  ) u_rr_select (
    .req      (nb_req_s),
    .start    (rr_ptr_r),
    .count    (nb_count_s),
    .pick_oh  (pick_oh_s),
    .pick_vld (pick_vld_s)
  );

  // Mux picked packets, shift them behind the branch packet when it holds slot 0.
  always_comb begin
    grant_s             = '0;
    grant_s[BRANCH_IDX] = branch_go_s;
    for (int p = 0; p < COMPLETE_WIDTH; p++) begin
      pick_pkt_s[p] = '0;
      grant_s       = grant_s | pick_oh_s[p];
      for (int i = 0; i < NUM_FU; i++) begin
        pick_pkt_s[p] = FU_COMPLETE_PACKET'(pick_pkt_s[p] |
                        (bus.fu_packet_in[i] & {$bits(FU_COMPLETE_PACKET){pick_oh_s[p][i]}}));
      end
    end
    out_nxt_s[0] = branch_go_s ? bus.fu_packet_in[BRANCH_IDX] : pick_pkt_s[0];
    for (int s = 1; s < COMPLETE_WIDTH; s++) begin
      out_nxt_s[s] = branch_go_s ? pick_pkt_s[s-1] : pick_pkt_s[s];
    end
    bus.complete_stall = bus.want_to_complete & ~grant_s;
  end

  // Pointer follows the last non-branch FU granted this cycle, else holds.
  always_comb begin
    rr_ptr_nxt_s = rr_ptr_r;
    for (int p = 0; p < COMPLETE_WIDTH; p++) begin
      if (pick_vld_s[p]) begin
        rr_ptr_nxt_s = ptr_after(oh_to_idx(pick_oh_s[p]));
      end else begin
        rr_ptr_nxt_s = rr_ptr_nxt_s;
      end
    end
  end

  // Completion bus and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < COMPLETE_WIDTH; s++) bus.complete_out[s] <= '0;
      rr_ptr_r <= PTR_W'(0);
    end else if (squash) begin
      for (int s = 0; s < COMPLETE_WIDTH; s++) bus.complete_out[s] <= '0;
      rr_ptr_r <= rr_ptr_r;
    end else begin
      for (int s = 0; s < COMPLETE_WIDTH; s++) bus.complete_out[s] <= out_nxt_s[s];
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed and randomized scoreboard bench for complete_arbiter.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   errors = 0;
  int   checks = 0;

  complete_arbiter_if bus ();

  complete_arbiter dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic FU_COMPLETE_PACKET mk_pkt(input int fu, input logic [31:0] val);
    FU_COMPLETE_PACKET p;
    p            = '0;
    p.valid      = 1'b1;
    p.dest_pr    = 6'(fu + 40);
    p.dest_value = val;
    p.rob_entry  = 5'(fu);
    p.target_pc  = val ^ 32'hA5A5_0000;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.want_to_complete = '0;
    for (int i = 0; i < NUM_FU; i++) bus.fu_packet_in[i] = '0;
    squash = 1'b0;
  endtask

  task automatic drive(input int fu, input FU_COMPLETE_PACKET p);
    bus.fu_packet_in[fu]     = p;
    bus.want_to_complete[fu] = 1'b1;
  endtask

  task automatic drop(input int fu);
    bus.fu_packet_in[fu]     = '0;
    bus.want_to_complete[fu] = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < NUM_FU; i++) drive(i, mk_pkt(i, 32'(i + 1)));
    #2;
    checks++;
    if (bus.complete_stall !== 8'hFF) begin
      errors++; $display("FAIL reset_stall_pre: got %h expected ff", bus.complete_stall);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.complete_stall !== 8'hFF) begin
        errors++; $display("FAIL reset_stall: got %h expected ff", bus.complete_stall);
      end
      checks++;
      if (bus.complete_out[0] !== '0 || bus.complete_out[1] !== '0) begin
        errors++; $display("FAIL reset_out: got %h %h expected 0", bus.complete_out[0], bus.complete_out[1]);
      end
      checks++;
      if (dut.rr_ptr_r !== 3'd0) begin
        errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.rr_ptr_r);
      end
    end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_branch();
    FU_COMPLETE_PACKET bp;
    do_reset();
    bp = '0;
    bp.valid = 1'b1; bp.rob_entry = 5'd3; bp.dest_pr = 6'd32;
    bp.if_take_branch = 1'b1; bp.target_pc = 32'd8; bp.dest_value = 32'h0000_0055;
    drive(BRANCH_IDX, bp);
    #2;
    checks++;
    if (bus.complete_stall !== 8'h00) begin
      errors++; $display("FAIL branch_stall: got %h expected 00", bus.complete_stall);
    end
    tick();
    drop(BRANCH_IDX);
    checks++;
    if (bus.complete_out[0] !== bp || bus.complete_out[1].valid !== 1'b0) begin
      errors++; $display("FAIL branch_out: got %h / v%b expected %h / v0", bus.complete_out[0], bus.complete_out[1].valid, bp);
    end
    tick();
    checks++;
    if (bus.complete_out[0].valid !== 1'b0) begin
      errors++; $display("FAIL branch_one_cycle: got valid %b expected 0", bus.complete_out[0].valid);
    end
  endtask

  task automatic test_branch_alus();
    do_reset();
    drive(BRANCH_IDX, mk_pkt(BRANCH_IDX, 32'h700));
    for (int i = 0; i < 3; i++) drive(i, mk_pkt(i, 32'(32'h100 + i)));
    #2;
    checks++;
    if (bus.complete_stall !== 8'b0000_0110) begin
      errors++; $display("FAIL balu_stall: got %h expected 06", bus.complete_stall);
    end
    tick();
    drop(BRANCH_IDX);
    drop(0);
    checks++;
    if (bus.complete_out[0] !== mk_pkt(BRANCH_IDX, 32'h700) || bus.complete_out[1] !== mk_pkt(0, 32'h100)) begin
      errors++; $display("FAIL balu_out: got %h %h", bus.complete_out[0], bus.complete_out[1]);
    end
    checks++;
    if (dut.rr_ptr_r !== 3'd1) begin
      errors++; $display("FAIL balu_ptr: got %0d expected 1", dut.rr_ptr_r);
    end
    #2;
    checks++;
    if (bus.complete_stall !== 8'h00) begin
      errors++; $display("FAIL balu_stall2: got %h expected 00", bus.complete_stall);
    end
    tick();
    drop(1);
    drop(2);
    checks++;
    if (bus.complete_out[0] !== mk_pkt(1, 32'h101) || bus.complete_out[1] !== mk_pkt(2, 32'h102)) begin
      errors++; $display("FAIL balu_out2: got %h %h", bus.complete_out[0], bus.complete_out[1]);
    end
    checks++;
    if (dut.rr_ptr_r !== 3'd3) begin
      errors++; $display("FAIL balu_ptr2: got %0d expected 3", dut.rr_ptr_r);
    end
  endtask

  task automatic test_all_nonbranch();
    logic [7:0] exp_g [4] = '{8'h03, 8'h0C, 8'h30, 8'h40};
    int         exp_s0 [4] = '{0, 2, 4, 6};
    int         exp_s1 [4] = '{1, 3, 5, -1};
    logic [7:0] pend;
    do_reset();
    pend = 8'h7F;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (pend[i]) drive(i, mk_pkt(i, 32'(32'h100 + i)));
        else         drop(i);
      end
      #2;
      checks++;
      if (bus.complete_stall !== (pend & ~exp_g[c])) begin
        errors++; $display("FAIL rr_stall c%0d: got %h expected %h", c, bus.complete_stall, pend & ~exp_g[c]);
      end
      tick();
      pend = pend & ~exp_g[c];
      checks++;
      if (bus.complete_out[0] !== mk_pkt(exp_s0[c], 32'(32'h100 + exp_s0[c]))) begin
        errors++; $display("FAIL rr_slot0 c%0d: got %h expected fu%0d", c, bus.complete_out[0], exp_s0[c]);
      end
      checks++;
      if (exp_s1[c] < 0 ? (bus.complete_out[1] !== '0)
                        : (bus.complete_out[1] !== mk_pkt(exp_s1[c], 32'(32'h100 + exp_s1[c])))) begin
        errors++; $display("FAIL rr_slot1 c%0d: got %h expected fu%0d", c, bus.complete_out[1], exp_s1[c]);
      end
    end
    checks++;
    if (dut.rr_ptr_r !== 3'd0) begin
      errors++; $display("FAIL rr_ptr_wrap: got %0d expected 0", dut.rr_ptr_r);
    end
    clear_inputs();
  endtask

  task automatic test_squash();
    do_reset();
    drive(3, mk_pkt(3, 32'h103));
    drive(4, mk_pkt(4, 32'h104));
    squash = 1'b1;
    #2;
    checks++;
    if (bus.complete_stall !== 8'h18) begin
      errors++; $display("FAIL squash_stall: got %h expected 18", bus.complete_stall);
    end
    tick();
    squash = 1'b0;
    checks++;
    if (bus.complete_out[0].valid !== 1'b0 || bus.complete_out[1].valid !== 1'b0) begin
      errors++; $display("FAIL squash_out: got v%b v%b expected v0 v0", bus.complete_out[0].valid, bus.complete_out[1].valid);
    end
    checks++;
    if (dut.rr_ptr_r !== 3'd0) begin
      errors++; $display("FAIL squash_ptr: got %0d expected 0", dut.rr_ptr_r);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.complete_out[0] !== mk_pkt(3, 32'h103) || bus.complete_out[1] !== mk_pkt(4, 32'h104) || dut.rr_ptr_r !== 3'd5) begin
      errors++; $display("FAIL squash_retry: got %h %h ptr %0d", bus.complete_out[0], bus.complete_out[1], dut.rr_ptr_r);
    end
  endtask

  task automatic test_invalid_and_halt();
    FU_COMPLETE_PACKET hp;
    do_reset();
    bus.want_to_complete[2] = 1'b1;
    bus.fu_packet_in[2]     = '0;
    hp      = mk_pkt(5, 32'h105);
    hp.halt = 1'b1;
    drive(5, hp);
    #2;
    checks++;
    if (bus.complete_stall !== 8'h04) begin
      errors++; $display("FAIL invalid_stall: got %h expected 04", bus.complete_stall);
    end
    tick();
    clear_inputs();
    checks++;
    if (bus.complete_out[0] !== hp || bus.complete_out[1].valid !== 1'b0) begin
      errors++; $display("FAIL halt_out: got %h / v%b expected %h / v0", bus.complete_out[0], bus.complete_out[1].valid, hp);
    end
  endtask

  task automatic test_random();
    logic [NUM_FU-1:0] pend, taken;
    FU_COMPLETE_PACKET cur [NUM_FU];
    FU_COMPLETE_PACKET exp_p [COMPLETE_WIDTH];
    int age [NUM_FU];
    int used [COMPLETE_WIDTH];
    int n_exp, nv, id, load, worst, bad, found;
    do_reset();
    pend = '0;
    id   = 1;
    for (int i = 0; i < NUM_FU; i++) age[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      load = ((c / 500) % 3 == 0) ? 20 : (((c / 500) % 3 == 1) ? 50 : 95);
      for (int i = 0; i < NUM_FU; i++) begin
        if (!pend[i] && ($urandom_range(99, 0) < load)) begin
          cur[i]                = mk_pkt(i, 32'(id));
          cur[i].halt           = ($urandom_range(15, 0) == 0);
          cur[i].if_take_branch = (i == BRANCH_IDX) ? 1'($urandom_range(1, 0)) : 1'b0;
          id++;
          pend[i] = 1'b1;
        end
        if (pend[i]) drive(i, cur[i]);
        else         drop(i);
      end
      #2;
      checks++;
      if ((bus.complete_stall & ~bus.want_to_complete) !== '0) begin
        errors++; $display("FAIL rnd_stall_idle c%0d: stall %h want %h", c, bus.complete_stall, bus.want_to_complete);
      end
      if ($countones(pend) <= COMPLETE_WIDTH) begin
        checks++;
        if (bus.complete_stall !== '0) begin
          errors++; $display("FAIL rnd_fit c%0d: stall %h expected 00", c, bus.complete_stall);
        end
      end
      if (pend[BRANCH_IDX]) begin
        checks++;
        if (bus.complete_stall[BRANCH_IDX] !== 1'b0) begin
          errors++; $display("FAIL rnd_branch_prio c%0d: stall %h", c, bus.complete_stall);
        end
      end
      taken = pend & ~bus.complete_stall;
      n_exp = 0;
      worst = 0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (taken[i]) begin
          if (n_exp < COMPLETE_WIDTH) exp_p[n_exp] = cur[i];
          n_exp++;
        end
        age[i] = (pend[i] && bus.complete_stall[i]) ? age[i] + 1 : 0;
        worst  = (age[i] > worst) ? age[i] : worst;
      end
      checks++;
      if (worst > 7) begin
        errors++; $display("FAIL rnd_starve c%0d: stalled %0d cycles, limit 7", c, worst);
      end
      pend = pend & ~taken;
      tick();
      nv  = 0;
      bad = 0;
      for (int e = 0; e < COMPLETE_WIDTH; e++) used[e] = 0;
      for (int s = 0; s < COMPLETE_WIDTH; s++) begin
        if (bus.complete_out[s].valid === 1'b1) begin
          nv++;
          found = 0;
          for (int e = 0; e < COMPLETE_WIDTH; e++) begin
            if (found == 0 && e < n_exp && used[e] == 0 && bus.complete_out[s] === exp_p[e]) begin
              used[e] = 1;
              found   = 1;
            end
          end
          bad = (found == 0) ? 1 : bad;
        end
      end
      checks++;
      if (bad != 0 || nv != n_exp) begin
        errors++; $display("FAIL rnd_scoreboard c%0d: got %0d valid (unmatched=%0d) expected %0d", c, nv, bad, n_exp);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    test_reset();
    test_single_branch();
    test_branch_alus();
    test_all_nonbranch();
    test_squash();
    test_invalid_and_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
# complete_arbiter

Completion-stage arbiter between the functional units (ALU, multiplier, load/store, branch) and the complete/retire path. Each cycle it grants up to `COMPLETE_WIDTH` of the FUs requesting completion, registers the granted `FU_COMPLETE_PACKET`s onto the completion bus toward the ROB and the register-file writeback, and drives `complete_stall` back to every FU it refused. The branch FU has fixed top priority so branch resolution (`if_take_branch`, `target_pc`) reaches the ROB at the earliest cycle. The remaining FUs share the leftover slots round-robin.

## Interface
Parameters:
- `NUM_FU`, 8: FU instances; bit order fixed by `FU_STATE_PACKET`, with branch at index `BRANCH_IDX`.
- `COMPLETE_WIDTH`, 2: completion-bus slots per cycle, legal range 1..`NUM_FU`.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `squash`  in  1: mispredict flush from the ROB.
- `want_to_complete`  in  `FU_STATE_PACKET`: one request bit per FU.
- `fu_packet_in`  in  `FU_COMPLETE_PACKET [NUM_FU]`: FU output packets, held stable while stalled.
- `complete_stall`  out  `FU_STATE_PACKET`: combinational; 1 means the FU must hold its packet this cycle.
- `complete_out`  out  `FU_COMPLETE_PACKET [COMPLETE_WIDTH]`: registered completion bus.

## Operation
- A request from FU i is effective only when `want_to_complete[i]` is 1 and `fu_packet_in[i].valid` is 1.
- Grant order:
  - If the branch FU has an effective request, it takes slot 0.
  - Remaining slots go to the other effective requesters, scanned cyclically from `rr_ptr`, in slot order.
- `complete_stall[i]` = `want_to_complete[i]` & ~`grant[i]`. If `want_to_complete[i]` is 0, the stall bit is 0.
- Next `complete_out[s]`:
  - The packet of the FU granted slot s.
  - Slots with no grant get `valid`=0 and all other fields 0.
- `rr_ptr` (width `$clog2(NUM_FU)`) update:
  - If any non-branch FU was granted, the pointer moves to (index of the last non-branch FU granted) + 1, modulo `NUM_FU`.
  - If the pointer lands on `BRANCH_IDX`, it skips to the next index.
  - If no non-branch FU was granted, the pointer holds.
- Packet fields are passed through unmodified: `dest_pr`, `dest_value`, `rob_entry`, `if_take_branch`, `target_pc`, `halt`.
- Squash:
  - On the next edge, every `complete_out` valid bit is 0 and `rr_ptr` holds.
  - During the squash cycle, `complete_stall` is 1 for every requesting FU, so no packet is consumed.
- Halt: a packet with `halt`=1 is arbitrated like any other. Ordering is the ROB's job.

## Timing
- Reset values:
  - Every `complete_out` entry: `valid`=0, all fields 0.
  - `rr_ptr`=0.
  - While `reset` is high, `complete_stall` equals `want_to_complete`, so every requester stalls.
- Latency:
  - A grant in cycle N places the packet on `complete_out` in cycle N+1.
  - Each packet appears on `complete_out` for exactly one cycle.
- Handshake: a stalled FU re-requests every cycle with the same packet. The arbiter holds no per-FU state other than `rr_ptr`.
- All requesters fit: with at most `COMPLETE_WIDTH` effective requests, nothing stalls.
- Over-subscription: with `NUM_FU` requesters and width 2, each non-branch FU is granted within ceil((`NUM_FU`-1)/1) cycles while the branch FU is requesting, and ceil((`NUM_FU`-1)/2) cycles otherwise.
- Reset takes priority over squash, which takes priority over normal arbitration.
- `want_to_complete`=1 with `valid`=0 produces no grant and `complete_stall`=1. An FU must not do this; the bench flags it as an FU bug.

## Structure
- Already in the shared package (`sys_defs`): `FU_STATE_PACKET`, `FU_COMPLETE_PACKET`.
- To add to `sys_defs`: `NUM_FU`, `COMPLETE_WIDTH`, `BRANCH_IDX`.
- The arbiter drives the `complete_stall` input of each FU stage instance, including `branch_stage`, and takes their `want_to_complete` and `fu_packet_out`.
- Sub-module: `rr_select`, a combinational cyclic picker (request vector, start pointer, count) returning one-hot grants. Instantiate it once for the non-branch slots.

## Test plan
- Reset then idle: hold reset 2 cycles with all 8 requests high → `complete_stall`=8'hFF during reset, `complete_out[*].valid`=0, `rr_ptr`=0.
- Single branch: branch requests with `rob_entry`=3, `dest_pr`=32, `if_take_branch`=1, `target_pc`=8 → `complete_stall`=0, and next cycle `complete_out[0]` carries exactly those values with `valid`=1.
- Branch plus 3 ALUs (indices 0, 1, 2), width 2 → branch gets slot 0 and ALU0 slot 1; ALU1 and ALU2 stall; `rr_ptr`=1. The next cycle ALU1 is granted.
- All 7 non-branch FUs requesting continuously, no branch → 2 grants per cycle in index order. Every FU completes exactly once within 4 cycles, and the stall bits match the refused set each cycle.
- Squash while 2 packets are granted → the following cycle both `complete_out` valids are 0, and every requester sees `complete_stall`=1 during the squash cycle.
- Random request vectors over 10k cycles → a scoreboard confirms:
  - no packet is lost or duplicated;
  - no FU starves for more than 7 cycles;
  - `complete_stall` is never 1 when the FU is not requesting.
